// File: rtl/conv_buf_pkg.sv
// conv_buf_pkg -- shared definitions for the strided buffer write path.
//   Descriptor shape layout (B_SHAPE bits): w[8:0], h[17:9], n_wrap_c[24:18].
//   B_BEATS holds the largest tile beat count, 511*511*127.
//   Scheduler state encoding, sticky error bit indices, and helpers that
//   derive beat count / validity from a packed shape.
package conv_buf_pkg;

  localparam int W_LSB   = 0;
  localparam int H_LSB   = 9;
  localparam int C_LSB   = 18;
  localparam int W_W     = 9;
  localparam int H_W     = 9;
  localparam int C_W     = 7;

  localparam int B_SHAPE = 25;
  localparam int B_BEATS = 25;
  localparam int B_SUM   = 7;
  localparam int OCC_W   = 2;

  localparam int ERR_SHAPE = 0;
  localparam int ERR_LAST  = 1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CALC      = 3'd1,
    WAIT_BANK = 3'd2,
    STREAM    = 3'd3,
    CHECK     = 3'd4
  } state_e;

  // Full-width product; 9+9+7 bits fits B_BEATS exactly, nothing truncates.
  function automatic logic [B_BEATS-1:0] tile_beats(input logic [B_SHAPE-1:0] s);
    return B_BEATS'(s[W_LSB +: W_W]) * B_BEATS'(s[H_LSB +: H_W]) *
           B_BEATS'(s[C_LSB +: C_W]);
  endfunction

  // A zero field would leave the writer spinning forever.
  function automatic logic shape_has_zero(input logic [B_SHAPE-1:0] s);
    return (s[W_LSB +: W_W] == '0) || (s[H_LSB +: H_W] == '0) ||
           (s[C_LSB +: C_W] == '0);
  endfunction

endpackage

// File: rtl/strided_write_scheduler_if.sv
// strided_write_scheduler_if -- bundle of every non-clock signal around the
// scheduler.
//   cmd_*        : descriptor handshake from the layer controller
//   s_*          : DMA beat stream
//   wr_*, shape, n_wrap_c_sum : writer side (wr_last/wr_tog come back)
//   rd_release   : consumer frees the oldest bank
//   occ, tile_done, busy, err : status
// modport master = the scheduler, modport slave = its surroundings.
interface strided_write_scheduler_if #(
  parameter int DATA_WIDTH = 64
);
  import conv_buf_pkg::*;

  logic                   cmd_valid;
  logic                   cmd_ready;
  logic [B_SHAPE-1:0]     cmd_shape;
  logic [B_SUM-1:0]       cmd_n_wrap_c_sum;
  logic                   s_valid;
  logic                   s_ready;
  logic [DATA_WIDTH-1:0]  s_data;
  logic [DATA_WIDTH-1:0]  wr_di;
  logic                   wr_en;
  logic [B_SHAPE-1:0]     shape;
  logic [B_SUM-1:0]       n_wrap_c_sum;
  logic                   wr_last;
  logic                   wr_tog;
  logic                   rd_release;
  logic [OCC_W-1:0]       occ;
  logic                   tile_done;
  logic                   busy;
  logic [1:0]             err;

  modport master (
    input  cmd_valid, cmd_shape, cmd_n_wrap_c_sum, s_valid, s_data,
           wr_last, wr_tog, rd_release,
    output cmd_ready, s_ready, wr_di, wr_en, shape, n_wrap_c_sum,
           occ, tile_done, busy, err
  );

  modport slave (
    output cmd_valid, cmd_shape, cmd_n_wrap_c_sum, s_valid, s_data,
           wr_last, wr_tog, rd_release,
    input  cmd_ready, s_ready, wr_di, wr_en, shape, n_wrap_c_sum,
           occ, tile_done, busy, err
  );

endinterface

// File: rtl/bank_occ_counter.sv
// bank_occ_counter -- ping-pong bank occupancy.
//   clk, rstn : clock, synchronous active-low reset
//   inc_i     : a tile has been committed to a bank
//   dec_i     : consumer released the oldest bank
//   occ_o     : banks filled and not yet released, saturates at N_BANK
module bank_occ_counter
  import conv_buf_pkg::*;
#(
  parameter int N_BANK = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [OCC_W-1:0] occ_o
);

  localparam logic [OCC_W-1:0] OCC_MAX = OCC_W'(N_BANK);

  logic [OCC_W-1:0] occ_q, occ_d;
  logic             dec_ok;

  // A release with nothing held is spurious and is dropped before netting
  // against a same-cycle increment.
  assign dec_ok = dec_i && (occ_q != '0);

  always_comb begin
    occ_d = occ_q;
    if (inc_i && !dec_ok && (occ_q != OCC_MAX))
      occ_d = occ_q + 1'b1;
    else if (dec_ok && !inc_i)
      occ_d = occ_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rstn) occ_q <= '0;
    else       occ_q <= occ_d;
  end

  assign occ_o = occ_q;

endmodule

// File: rtl/strided_write_scheduler.sv
// strided_write_scheduler -- meters exactly one tile of DMA beats into the
// strided buffer writer per accepted descriptor.
//   clk, rstn : clock, synchronous active-low reset (shared with the writer)
//   bus       : strided_write_scheduler_if.master
//     cmd_*      descriptor in, accepted only in IDLE
//     s_*        beat stream, ready only in STREAM
//     wr_di/en   combinational pass-through of accepted beats
//     shape, n_wrap_c_sum  latched per tile, stable until the next accept
//     wr_last/wr_tog       writer completion / bank toggle, cross-checked
//     rd_release, occ      double-buffer occupancy
//     tile_done, busy, err status; err is sticky until reset
module strided_write_scheduler
  import conv_buf_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int N_BANK     = 2
) (
  input  logic                       clk,
  input  logic                       rstn,
  strided_write_scheduler_if.master  bus
);

  localparam logic [2:0] S_IDLE   = 3'(IDLE);
  localparam logic [2:0] S_CALC   = 3'(CALC);
  localparam logic [2:0] S_WAIT   = 3'(WAIT_BANK);
  localparam logic [2:0] S_STREAM = 3'(STREAM);
  localparam logic [2:0] S_CHECK  = 3'(CHECK);

  localparam logic [OCC_W-1:0]   OCC_MAX  = OCC_W'(N_BANK);
  localparam logic [B_BEATS-1:0] ONE_BEAT = B_BEATS'(1);

  logic [2:0]            state_q, state_d;
  logic [B_SHAPE-1:0]    shape_q, shape_d;
  logic [B_SUM-1:0]      sum_q, sum_d;
  logic [B_BEATS-1:0]    beats_q, beats_d;
  logic [1:0]            err_q, err_d;
  logic                  tog_q;
  logic                  pend_q, pend_d;

  logic [OCC_W-1:0]      occ;
  logic [DATA_WIDTH-1:0] beat;
  logic                  in_stream, in_check, beat_acc, tog_chg;

  assign in_stream = (state_q == S_STREAM);
  assign in_check  = (state_q == S_CHECK);
  assign beat_acc  = bus.s_valid && in_stream;
  assign tog_chg   = bus.wr_tog ^ tog_q;

  // Beats go straight through; the writer adds its own register stage.
  assign beat             = bus.s_data;
  assign bus.wr_di        = beat;
  assign bus.wr_en        = beat_acc;

  assign bus.cmd_ready    = (state_q == S_IDLE);
  assign bus.s_ready      = in_stream;
  assign bus.shape        = shape_q;
  assign bus.n_wrap_c_sum = sum_q;
  assign bus.tile_done    = in_check;
  assign bus.busy         = (state_q != S_IDLE);
  assign bus.err          = err_q;
  assign bus.occ          = occ;

  // CHECK always commits a bank, even on a wr_last mismatch, so the
  // consumer side never deadlocks waiting for a tile.
  bank_occ_counter #(.N_BANK(N_BANK)) u_occ (
    .clk   (clk),
    .rstn  (rstn),
    .inc_i (in_check),
    .dec_i (bus.rd_release),
    .occ_o (occ)
  );

  always_comb begin
    state_d = state_q;
    shape_d = shape_q;
    sum_d   = sum_q;
    beats_d = beats_q;
    err_d   = err_q;

    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          shape_d = bus.cmd_shape;
          sum_d   = bus.cmd_n_wrap_c_sum;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        if (shape_has_zero(shape_q)) begin
          err_d[ERR_SHAPE] = 1'b1;
          state_d          = S_IDLE;
        end else begin
          beats_d = tile_beats(shape_q);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (occ < OCC_MAX) state_d = S_STREAM;
      end
      S_STREAM: begin
        if (beat_acc) begin
          beats_d = beats_q - ONE_BEAT;
          if (beats_q == ONE_BEAT) state_d = S_CHECK;
        end
        // The writer can only legitimately flag last in CHECK.
        if (bus.wr_last) err_d[ERR_LAST] = 1'b1;
      end
      S_CHECK: begin
        if (!bus.wr_last) err_d[ERR_LAST] = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Toggle bookkeeping: each tile_done owes exactly one wr_tog edge,
    // which may land in the CHECK cycle or any time before the next one.
    if (tog_chg && !pend_q && !in_check) err_d[ERR_LAST] = 1'b1;
    if (in_check && pend_q && !tog_chg)  err_d[ERR_LAST] = 1'b1;
    pend_d = in_check ? (pend_q | ~tog_chg) : (pend_q & ~tog_chg);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      shape_q <= '0;
      sum_q   <= '0;
      beats_q <= '0;
      err_q   <= '0;
      tog_q   <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shape_q <= shape_d;
      sum_q   <= sum_d;
      beats_q <= beats_d;
      err_q   <= err_d;
      tog_q   <= bus.wr_tog;
      pend_q  <= pend_d;
    end
  end

endmodule

// File: tb/tb_strided_write_scheduler.sv
// Bench for strided_write_scheduler: a behavioural writer drives wr_last /
// wr_tog, a negedge monitor records written beats and tile_done pulses, and
// each scenario task compares against expectations from tile arithmetic.
module tb_strided_write_scheduler;
  import conv_buf_pkg::*;

  localparam int DW = 64;
  localparam int NB = 2;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  strided_write_scheduler_if #(.DATA_WIDTH(DW)) bus();

  strided_write_scheduler #(.DATA_WIDTH(DW), .N_BANK(NB)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int occ_m = 0;
  int td_cnt = 0;
  int td_nolast = 0;
  logic [DW-1:0] sent_q[$];
  logic [DW-1:0] mon_q[$];

  function automatic int tile_n(input logic [B_SHAPE-1:0] s);
    return int'(s[8:0]) * int'(s[17:9]) * int'(s[24:18]);
  endfunction

  // Writer: registers wr_en, flags last on the tile's final registered
  // write, flips its bank toggle as that write completes.
  logic wen_r;
  int   wcnt;
  logic tog;
  always @(posedge clk) begin
    if (!rstn) begin
      wen_r <= 1'b0; wcnt <= 0; tog <= 1'b0;
    end else begin
      wen_r <= bus.wr_en;
      if (wen_r) begin
        if (wcnt == tile_n(bus.shape) - 1) begin
          wcnt <= 0; tog <= ~tog;
        end else wcnt <= wcnt + 1;
      end
    end
  end
  assign bus.wr_last = wen_r && (wcnt == tile_n(bus.shape) - 1);
  assign bus.wr_tog  = tog;

  always @(negedge clk) begin
    if (rstn) begin
      if (bus.wr_en) mon_q.push_back(bus.wr_di);
      if (bus.tile_done) begin
        td_cnt++;
        if (!bus.wr_last) td_nolast++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int first_diff();
    if (mon_q.size() != sent_q.size()) return -2;
    foreach (sent_q[i]) if (mon_q[i] !== sent_q[i]) return i;
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    rstn = 1'b0;
    bus.cmd_valid = 1'b0; bus.s_valid = 1'b0; bus.rd_release = 1'b0;
    tick(); tick();
    rstn = 1'b1;
    occ_m = 0;
  endtask

  task automatic send_cmd(input int w, input int h, input int c, input int sum);
    bit acc = 1'b0;
    bus.cmd_valid        = 1'b1;
    bus.cmd_shape        = {7'(c), 9'(h), 9'(w)};
    bus.cmd_n_wrap_c_sum = 7'(sum);
    for (int i = 0; i < 100 && !acc; i++) begin
      #1; acc = bus.cmd_ready;
      @(posedge clk); #1;
    end
    bus.cmd_valid = 1'b0;
    n_cmp++;
    if (!acc) begin n_bad++; $display("FAIL cmd_accept: cmd_ready=0 for 100 cycles, required 1"); end
  endtask

  task automatic drive_beats(input int n, input int pct, input bit seq, output int got);
    int cyc = 0;
    got = 0;
    sent_q.delete(); mon_q.delete();
    while (got < n && cyc < n * 4 + 60) begin
      bus.s_valid = ($urandom_range(99, 0) < pct);
      bus.s_data  = seq ? DW'(got) : {$urandom, $urandom};
      #1;
      if (bus.s_valid && bus.s_ready) begin sent_q.push_back(bus.s_data); got++; end
      @(posedge clk); #1;
      cyc++;
    end
    bus.s_valid = 1'b0;
  endtask

  task automatic small_tile(input int w, input int h, input int c);
    int got;
    send_cmd(w, h, c, 1);
    drive_beats(w * h * c, 100, 1'b0, got);
    tick();
    occ_m = (occ_m < NB) ? occ_m + 1 : NB;
  endtask

  task automatic test_reset();
    apply_reset();
    n_cmp++;
    if ({bus.cmd_ready, bus.s_ready, bus.busy, bus.tile_done, bus.wr_en} !== 5'b10000) begin
      n_bad++; $display("FAIL reset_ctl: {cmd_ready,s_ready,busy,tile_done,wr_en}=%b required 10000",
        {bus.cmd_ready, bus.s_ready, bus.busy, bus.tile_done, bus.wr_en});
    end
    n_cmp++;
    if ({bus.occ, bus.err} !== 4'b0) begin
      n_bad++; $display("FAIL reset_stat: occ=%0d err=%b required 0/00", bus.occ, bus.err);
    end
    n_cmp++;
    if ({bus.shape, bus.n_wrap_c_sum} !== 32'b0) begin
      n_bad++; $display("FAIL reset_shape: shape=%h sum=%h required 0", bus.shape, bus.n_wrap_c_sum);
    end
  endtask

  task automatic test_basic();
    int got, d;
    logic tog0;
    apply_reset();
    tog0 = bus.wr_tog;
    send_cmd(2, 3, 4, 4);
    drive_beats(24, 100, 1'b1, got);
    n_cmp++;
    if (got != 24) begin n_bad++; $display("FAIL basic_count: accepted %0d required 24", got); end
    d = first_diff();
    n_cmp++;
    if (d != -1) begin n_bad++; $display("FAIL basic_data: wr_di diverges at %0d (%0d written) required none", d, mon_q.size()); end
    bus.s_valid = 1'b1; #1;
    n_cmp++;
    if ({bus.tile_done, bus.wr_last, bus.wr_en} !== 3'b110) begin
      n_bad++; $display("FAIL basic_done: {tile_done,wr_last,wr_en}=%b required 110",
        {bus.tile_done, bus.wr_last, bus.wr_en});
    end
    bus.s_valid = 1'b0;
    @(posedge clk); #1;
    occ_m++;
    n_cmp++;
    if (bus.occ !== 2'(occ_m) || bus.tile_done !== 1'b0 || bus.busy !== 1'b0) begin
      n_bad++; $display("FAIL basic_occ: occ=%0d tile_done=%b busy=%b required %0d/0/0",
        bus.occ, bus.tile_done, bus.busy, occ_m);
    end
    tick();
    n_cmp++;
    if (bus.wr_tog !== ~tog0 || bus.err !== 2'b00) begin
      n_bad++; $display("FAIL basic_tog: wr_tog=%b err=%b required %b/00", bus.wr_tog, bus.err, ~tog0);
    end
    n_cmp++;
    if (bus.shape !== {7'(4), 9'(3), 9'(2)} || bus.n_wrap_c_sum !== 7'(4)) begin
      n_bad++; $display("FAIL basic_shape: shape=%h sum=%0d required %h/4",
        bus.shape, bus.n_wrap_c_sum, {7'(4), 9'(3), 9'(2)});
    end
  endtask

  task automatic test_back_to_back();
    int got, td0, seen;
    apply_reset();
    td0 = td_cnt;
    small_tile(1, 1, 2);
    small_tile(1, 1, 2);
    n_cmp++;
    if (bus.occ !== 2'(occ_m)) begin n_bad++; $display("FAIL b2b_full: occ=%0d required %0d", bus.occ, occ_m); end
    send_cmd(1, 1, 2, 2);
    seen = 0;
    bus.s_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1; if (bus.s_ready) seen++;
      @(posedge clk); #1;
    end
    bus.s_valid = 1'b0;
    n_cmp++;
    if (seen != 0 || bus.busy !== 1'b1) begin
      n_bad++; $display("FAIL b2b_park: s_ready cycles=%0d busy=%b required 0/1", seen, bus.busy);
    end
    bus.rd_release = 1'b1; tick(); bus.rd_release = 1'b0;
    occ_m--;
    drive_beats(2, 100, 1'b0, got);
    tick();
    occ_m++;
    n_cmp++;
    if (got != 2 || first_diff() != -1) begin
      n_bad++; $display("FAIL b2b_tile3: accepted %0d diff=%0d required 2/-1", got, first_diff());
    end
    n_cmp++;
    if (bus.occ !== 2'(occ_m) || td_cnt - td0 != 3 || bus.err !== 2'b00) begin
      n_bad++; $display("FAIL b2b_end: occ=%0d tiles=%0d err=%b required %0d/3/00",
        bus.occ, td_cnt - td0, bus.err, occ_m);
    end
  endtask

  task automatic test_gaps();
    int got, d, nl0;
    apply_reset();
    nl0 = td_nolast;
    send_cmd(5, 2, 3, int'($urandom_range(127, 1)));
    drive_beats(30, 50, 1'b0, got);
    d = first_diff();
    n_cmp++;
    if (got != 30 || d != -1) begin
      n_bad++; $display("FAIL gaps_data: accepted %0d diff=%0d required 30/-1", got, d);
    end
    #1;
    n_cmp++;
    if (bus.tile_done !== 1'b1 || bus.wr_last !== 1'b1) begin
      n_bad++; $display("FAIL gaps_last: tile_done=%b wr_last=%b required 1/1", bus.tile_done, bus.wr_last);
    end
    tick();
    occ_m++;
    n_cmp++;
    if (bus.err !== 2'b00 || bus.occ !== 2'(occ_m) || td_nolast != nl0) begin
      n_bad++; $display("FAIL gaps_end: err=%b occ=%0d nolast=%0d required 00/%0d/%0d",
        bus.err, bus.occ, td_nolast, occ_m, nl0);
    end
  endtask

  task automatic test_bad_shape();
    int got, td0, acc, w, h, c;
    apply_reset();
    small_tile(1, 1, 1);
    td0 = td_cnt;
    send_cmd(3, 0, 2, 5);
    acc = 0;
    bus.s_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1; if (bus.s_ready) acc++;
      @(posedge clk); #1;
    end
    bus.s_valid = 1'b0;
    n_cmp++;
    if (acc != 0 || bus.err !== 2'b01 || bus.busy !== 1'b0) begin
      n_bad++; $display("FAIL bad_shape: accepts=%0d err=%b busy=%b required 0/01/0", acc, bus.err, bus.busy);
    end
    n_cmp++;
    if (td_cnt != td0 || bus.occ !== 2'(occ_m)) begin
      n_bad++; $display("FAIL bad_drop: tiles=%0d occ=%0d required 0/%0d", td_cnt - td0, bus.occ, occ_m);
    end
    w = int'($urandom_range(4, 1)); h = int'($urandom_range(4, 1)); c = int'($urandom_range(4, 1));
    send_cmd(w, h, c, 3);
    drive_beats(w * h * c, 70, 1'b0, got);
    tick();
    occ_m++;
    n_cmp++;
    if (got != w * h * c || first_diff() != -1) begin
      n_bad++; $display("FAIL bad_next: accepted %0d diff=%0d required %0d/-1", got, first_diff(), w * h * c);
    end
    n_cmp++;
    if (bus.occ !== 2'(occ_m) || bus.err !== 2'b01 || td_cnt != td0 + 1) begin
      n_bad++; $display("FAIL bad_next_end: occ=%0d err=%b tiles=%0d required %0d/01/1",
        bus.occ, bus.err, td_cnt - td0, occ_m);
    end
  endtask

  task automatic test_occ_edges();
    int got;
    apply_reset();
    bus.rd_release = 1'b1; tick(); bus.rd_release = 1'b0;
    n_cmp++;
    if (bus.occ !== 2'd0) begin n_bad++; $display("FAIL occ_floor: occ=%0d required 0", bus.occ); end
    small_tile(1, 2, 1);
    send_cmd(2, 1, 1, 1);
    drive_beats(2, 100, 1'b0, got);
    bus.rd_release = 1'b1; tick(); bus.rd_release = 1'b0;
    n_cmp++;
    if (bus.occ !== 2'(occ_m)) begin n_bad++; $display("FAIL occ_same: occ=%0d required %0d", bus.occ, occ_m); end
    bus.rd_release = 1'b1; tick(); tick(); bus.rd_release = 1'b0;
    n_cmp++;
    if (bus.occ !== 2'd0 || bus.err !== 2'b00) begin
      n_bad++; $display("FAIL occ_drain: occ=%0d err=%b required 0/00", bus.occ, bus.err);
    end
  endtask

  task automatic test_reset_mid();
    int got;
    apply_reset();
    small_tile(1, 1, 1);
    send_cmd(2, 3, 4, 4);
    drive_beats(10, 100, 1'b0, got);
    rstn = 1'b0; tick(); rstn = 1'b1;
    occ_m = 0;
    bus.s_valid = 1'b1; #1;
    n_cmp++;
    if ({bus.busy, bus.s_ready, bus.wr_en} !== 3'b000 || bus.occ !== 2'd0) begin
      n_bad++; $display("FAIL mid_reset: busy=%b s_ready=%b wr_en=%b occ=%0d required 0/0/0/0",
        bus.busy, bus.s_ready, bus.wr_en, bus.occ);
    end
    bus.s_valid = 1'b0;
    @(posedge clk); #1;
    send_cmd(2, 3, 4, 4);
    drive_beats(24, 80, 1'b0, got);
    #1;
    n_cmp++;
    if (got != 24 || first_diff() != -1 || bus.tile_done !== 1'b1) begin
      n_bad++; $display("FAIL mid_retile: accepted %0d diff=%0d tile_done=%b required 24/-1/1",
        got, first_diff(), bus.tile_done);
    end
    @(posedge clk); #1;
    tick();
    occ_m++;
    n_cmp++;
    if (bus.err !== 2'b00 || bus.occ !== 2'(occ_m)) begin
      n_bad++; $display("FAIL mid_end: err=%b occ=%0d required 00/%0d", bus.err, bus.occ, occ_m);
    end
  endtask

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_shape = '0; bus.cmd_n_wrap_c_sum = '0;
    bus.s_valid = 1'b0; bus.s_data = '0; bus.rd_release = 1'b0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_gaps();
    test_bad_shape();
    test_occ_edges();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
